// File: rtl/neo_sound_latch_if.sv
`default_nettype none
// ============================================================================
//  Module      : neo_sound_latch_if
//  Description : Bus bundle between the 68K / Z80 (D0) strobe side and the
//                sound command/reply mailbox.
//                slave  modport : the mailbox itself
//                master modport : whatever drives the strobes and data
//  Signals     :
//    nSDW           68K command write strobe, active-low level
//    M68K_DATA[7:0] 68K command byte, valid while nSDW low
//    nM68K_RDREPLY  68K reply read strobe, active-low level
//    M68K_REPLY     reply byte presented to the 68K bus
//    nSDZ80R        Z80 command read strobe, active-low
//    nSDZ80W        Z80 reply write strobe, active-low
//    nSDZ80CLR      Z80 command clear strobe, active-low
//    SDD_IN[7:0]    Z80 data bus, valid while nSDZ80W low
//    SDD_OUT[7:0]   command byte presented to the Z80 bus
//    CMD_PENDING    unread command present
//    CMD_OVR        sticky command overrun
//    REPLY_PENDING  unread reply present
//    NMI_REQ        one-cycle pulse per accepted command
//  Revision    : 1.0  initial release
// ============================================================================
interface neo_sound_latch_if;
  logic       nSDW;
  logic [7:0] M68K_DATA;
  logic       nM68K_RDREPLY;
  logic [7:0] M68K_REPLY;
  logic       nSDZ80R;
  logic       nSDZ80W;
  logic       nSDZ80CLR;
  logic [7:0] SDD_IN;
  logic [7:0] SDD_OUT;
  logic       CMD_PENDING;
  logic       CMD_OVR;
  logic       REPLY_PENDING;
  logic       NMI_REQ;

  modport slave (
    input  nSDW, M68K_DATA, nM68K_RDREPLY, nSDZ80R, nSDZ80W, nSDZ80CLR, SDD_IN,
    output M68K_REPLY, SDD_OUT, CMD_PENDING, CMD_OVR, REPLY_PENDING, NMI_REQ
  );

  modport master (
    output nSDW, M68K_DATA, nM68K_RDREPLY, nSDZ80R, nSDZ80W, nSDZ80CLR, SDD_IN,
    input  M68K_REPLY, SDD_OUT, CMD_PENDING, CMD_OVR, REPLY_PENDING, NMI_REQ
  );
endinterface
`default_nettype wire

// File: rtl/neo_sound_latch.sv
`default_nettype none
// ============================================================================
//  Module      : neo_sound_latch
//  Description : 68K <-> Z80 sound command/reply mailbox. Sits behind the D0
//                Z80 controller and turns its decoded active-low strobes into
//                command/reply latch updates, pending/overrun flags and a
//                one-cycle NMI request per accepted command.
//  Ports       :
//    CLK        system clock, all logic on posedge
//    RESET      synchronous reset, active-high
//    bus        neo_sound_latch_if.slave (strobes, data, flags, NMI_REQ)
//  Parameters  :
//    FIFO_DEPTH command FIFO entries (power of 2, >= 2), only used when
//               SOUND_FIFO_EN is defined
//  Build macro :
//    SOUND_FIFO_EN  undefined -> single command latch (default)
//                   defined   -> FIFO_DEPTH-entry command FIFO
//  Revision    : 1.0  initial release
// ============================================================================
module neo_sound_latch #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  neo_sound_latch_if.slave bus
);

  // Depth sanity check; harmless in the single-latch build.
  generate
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("neo_sound_latch: FIFO_DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Strobe edge detection
  // bit 4: nSDW, 3: nM68K_RDREPLY, 2: nSDZ80R, 1: nSDZ80W, 0: nSDZ80CLR
  // --------------------------------------------------------------------------
  logic [4:0] strobe_now;
  logic [4:0] strobe_prev;
  logic       armed;
  logic [4:0] strobe_ev;

  assign strobe_now = {bus.nSDW, bus.nM68K_RDREPLY, bus.nSDZ80R,
                       bus.nSDZ80W, bus.nSDZ80CLR};

  // The previous-sample registers reset high, which on its own would make a
  // strobe held low through reset release look like a fresh falling edge.
  // 'armed' masks events for the first cycle after reset so that such a
  // strobe is simply absorbed into strobe_prev instead.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      strobe_prev <= 5'b11111;
      armed       <= 1'b0;
    end else begin
      strobe_prev <= strobe_now;
      armed       <= 1'b1;
    end
  end

  assign strobe_ev = ~strobe_now & strobe_prev & {5{armed}};

  logic ev_sdw;
  logic ev_rdreply;
  logic ev_z80r;
  logic ev_z80w;
  logic ev_clr;

  assign ev_sdw     = strobe_ev[4];
  assign ev_rdreply = strobe_ev[3];
  assign ev_z80r    = strobe_ev[2];
  assign ev_z80w    = strobe_ev[1];
  assign ev_clr     = strobe_ev[0];

  // --------------------------------------------------------------------------
  // NMI request: one cycle per accepted command write (also on FIFO overrun)
  // --------------------------------------------------------------------------
  logic nmi_req;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      nmi_req <= 1'b0;
    end else begin
      nmi_req <= ev_sdw;
    end
  end

  assign bus.NMI_REQ = nmi_req;

  // --------------------------------------------------------------------------
  // Reply path (Z80 -> 68K). A new reply always wins over a same-cycle read.
  // --------------------------------------------------------------------------
  logic [7:0] reply;
  logic       reply_pending;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      reply         <= 8'h00;
      reply_pending <= 1'b0;
    end else if (ev_z80w) begin
      reply         <= bus.SDD_IN;
      reply_pending <= 1'b1;
    end else if (ev_rdreply) begin
      reply_pending <= 1'b0;
    end
  end

  assign bus.M68K_REPLY    = reply;
  assign bus.REPLY_PENDING = reply_pending;

  // --------------------------------------------------------------------------
  // Command path (68K -> Z80)
  // --------------------------------------------------------------------------
`ifdef SOUND_FIFO_EN

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       sdd_out;
  logic             cmd_ovr;

  logic [PTR_W-1:0] base_rd;
  logic [PTR_W-1:0] base_wr;
  logic [CNT_W-1:0] base_cnt;
  logic             base_empty;
  logic             base_full;
  logic             rd_eff;
  logic             pass_thru;
  logic             pop;
  logic             push;
  logic             ovr_set;
  logic [PTR_W-1:0] rd_next;
  logic [PTR_W-1:0] wr_next;
  logic [CNT_W-1:0] cnt_next;
  logic [7:0]       out_next;
  logic             ovr_next;

  always_comb begin
    // A clear flushes first; any same-cycle write is then applied to the
    // empty FIFO, and a same-cycle read has nothing left to consume.
    base_rd    = ev_clr ? '0 : rd_ptr;
    base_wr    = ev_clr ? '0 : wr_ptr;
    base_cnt   = ev_clr ? '0 : count;
    base_empty = (base_cnt == '0);
    base_full  = (base_cnt == CNT_W'(FIFO_DEPTH));
    rd_eff     = ev_z80r & ~ev_clr;

    // Write and read on an empty FIFO: the byte goes straight to SDD_OUT and
    // is consumed, never occupying a slot.
    pass_thru  = ev_sdw & rd_eff & base_empty;
    pop        = rd_eff & ~base_empty;
    // When full, a same-cycle pop frees the slot the push needs.
    push       = ev_sdw & ~pass_thru & (~base_full | pop);
    ovr_set    = ev_sdw & base_full & ~pop;

    rd_next    = base_rd + PTR_W'(pop);
    wr_next    = base_wr + PTR_W'(push);
    cnt_next   = base_cnt + CNT_W'(push) - CNT_W'(pop);

    out_next   = sdd_out;
    if (pass_thru) begin
      out_next = bus.M68K_DATA;
    end else if (cnt_next != '0) begin
      // The new head is the byte being written now only when nothing older
      // survives this cycle.
      if (push && (base_cnt == CNT_W'(pop))) begin
        out_next = bus.M68K_DATA;
      end else begin
        out_next = mem[rd_next];
      end
    end else if (ev_clr) begin
      out_next = 8'h00;
    end

    ovr_next   = (ev_clr ? 1'b0 : cmd_ovr) | ovr_set;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      sdd_out <= 8'h00;
      cmd_ovr <= 1'b0;
    end else begin
      rd_ptr  <= rd_next;
      wr_ptr  <= wr_next;
      count   <= cnt_next;
      sdd_out <= out_next;
      cmd_ovr <= ovr_next;
    end
  end

  // Storage needs no reset: nothing reads a slot before it has been pushed.
  always_ff @(posedge CLK) begin
    if (!RESET && push) begin
      mem[base_wr] <= bus.M68K_DATA;
    end
  end

  assign bus.SDD_OUT     = sdd_out;
  assign bus.CMD_PENDING = (count != '0);
  assign bus.CMD_OVR     = cmd_ovr;

`else

  logic [7:0] cmd;
  logic       cmd_pending;
  logic       cmd_ovr;

  // Write dominates clear and read. Overrun only when an unread byte is
  // overwritten: a same-cycle read has consumed it, and a same-cycle clear
  // discards the sticky flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd         <= 8'h00;
      cmd_pending <= 1'b0;
      cmd_ovr     <= 1'b0;
    end else if (ev_sdw) begin
      cmd         <= bus.M68K_DATA;
      cmd_pending <= 1'b1;
      if (ev_clr) begin
        cmd_ovr <= 1'b0;
      end else if (cmd_pending && !ev_z80r) begin
        cmd_ovr <= 1'b1;
      end
    end else if (ev_clr) begin
      cmd         <= 8'h00;
      cmd_pending <= 1'b0;
      cmd_ovr     <= 1'b0;
    end else if (ev_z80r) begin
      cmd_pending <= 1'b0;
    end
  end

  assign bus.SDD_OUT     = cmd;
  assign bus.CMD_PENDING = cmd_pending;
  assign bus.CMD_OVR     = cmd_ovr;

`endif

endmodule
`default_nettype wire

// File: tb/tb_neo_sound_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neo_sound_latch
//  Description : Directed self-checking bench for neo_sound_latch. Expected
//                values are hand-computed constants. The FIFO scenario is
//                compiled in when SOUND_FIFO_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_neo_sound_latch;

  localparam logic [4:0] S_SDW  = 5'b00001;
  localparam logic [4:0] S_Z80R = 5'b00010;
  localparam logic [4:0] S_CLR  = 5'b00100;
  localparam logic [4:0] S_Z80W = 5'b01000;
  localparam logic [4:0] S_RDRP = 5'b10000;

  logic clk;
  logic rst;
  int   vec_count;
  int   err_count;

  neo_sound_latch_if sl_if ();

  neo_sound_latch #(.FIFO_DEPTH(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (sl_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [7:0] got,
                           input logic [7:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_on(input logic [4:0] mask);
    if (mask[0]) sl_if.nSDW          = 1'b0;
    if (mask[1]) sl_if.nSDZ80R       = 1'b0;
    if (mask[2]) sl_if.nSDZ80CLR     = 1'b0;
    if (mask[3]) sl_if.nSDZ80W       = 1'b0;
    if (mask[4]) sl_if.nM68K_RDREPLY = 1'b0;
    tick();
  endtask

  task automatic strobe_off();
    sl_if.nSDW          = 1'b1;
    sl_if.nSDZ80R       = 1'b1;
    sl_if.nSDZ80CLR     = 1'b1;
    sl_if.nSDZ80W       = 1'b1;
    sl_if.nM68K_RDREPLY = 1'b1;
    tick();
  endtask

  task automatic pulse(input logic [4:0] mask);
    strobe_on(mask);
    strobe_off();
  endtask

  task automatic write_cmd(input logic [7:0] data);
    sl_if.M68K_DATA = data;
    pulse(S_SDW);
  endtask

  initial begin
    vec_count = 0;
    err_count = 0;
    rst = 1'b1;
    sl_if.nSDW          = 1'b1;
    sl_if.nSDZ80R       = 1'b1;
    sl_if.nSDZ80CLR     = 1'b1;
    sl_if.nSDZ80W       = 1'b1;
    sl_if.nM68K_RDREPLY = 1'b1;
    sl_if.M68K_DATA     = 8'h00;
    sl_if.SDD_IN        = 8'h00;
    repeat (3) tick();

    check_vec("rst_sdd_out",   sl_if.SDD_OUT, 8'h00);
    check_vec("rst_reply",     sl_if.M68K_REPLY, 8'h00);
    check_vec("rst_flags", {4'h0, sl_if.CMD_PENDING, sl_if.CMD_OVR,
              sl_if.REPLY_PENDING, sl_if.NMI_REQ}, 8'h00);

    rst = 1'b0;
    repeat (2) tick();

`ifndef SOUND_FIFO_EN
    // First command
    sl_if.M68K_DATA = 8'h5A;
    strobe_on(S_SDW);
    check_vec("w1_nmi",     {7'h0, sl_if.NMI_REQ}, 8'h01);
    check_vec("w1_pending", {7'h0, sl_if.CMD_PENDING}, 8'h01);
    check_vec("w1_sdd_out", sl_if.SDD_OUT, 8'h5A);
    check_vec("w1_ovr",     {7'h0, sl_if.CMD_OVR}, 8'h00);
    strobe_off();
    check_vec("w1_nmi_end", {7'h0, sl_if.NMI_REQ}, 8'h00);
    pulse(S_CLR);

    // Overwrite without read, then clear
    write_cmd(8'h11);
    write_cmd(8'h22);
    check_vec("ovr_sdd_out", sl_if.SDD_OUT, 8'h22);
    check_vec("ovr_flag",    {7'h0, sl_if.CMD_OVR}, 8'h01);
    pulse(S_CLR);
    check_vec("clr_sdd_out", sl_if.SDD_OUT, 8'h00);
    check_vec("clr_flags", {6'h0, sl_if.CMD_PENDING, sl_if.CMD_OVR}, 8'h00);

    // Reply path
    sl_if.SDD_IN = 8'hA5;
    pulse(S_Z80W);
    check_vec("rep_pending", {7'h0, sl_if.REPLY_PENDING}, 8'h01);
    check_vec("rep_data",    sl_if.M68K_REPLY, 8'hA5);
    pulse(S_RDRP);
    check_vec("rep_rd_pending", {7'h0, sl_if.REPLY_PENDING}, 8'h00);
    check_vec("rep_rd_data",    sl_if.M68K_REPLY, 8'hA5);

    // Reply write and read together: write wins
    sl_if.SDD_IN = 8'h77;
    pulse(S_Z80W | S_RDRP);
    check_vec("rep_both_pending", {7'h0, sl_if.REPLY_PENDING}, 8'h01);
    check_vec("rep_both_data",    sl_if.M68K_REPLY, 8'h77);

    // Command write and Z80 read on the same edge
    write_cmd(8'h11);
    sl_if.M68K_DATA = 8'h33;
    sl_if.nSDW    = 1'b0;
    sl_if.nSDZ80R = 1'b0;
    #1;
    check_vec("wr_rd_old", sl_if.SDD_OUT, 8'h11);
    tick();
    check_vec("wr_rd_new",     sl_if.SDD_OUT, 8'h33);
    check_vec("wr_rd_pending", {7'h0, sl_if.CMD_PENDING}, 8'h01);
    check_vec("wr_rd_ovr",     {7'h0, sl_if.CMD_OVR}, 8'h00);
    strobe_off();

    // Plain read clears pending, data held
    pulse(S_Z80R);
    check_vec("rd_pending", {7'h0, sl_if.CMD_PENDING}, 8'h00);
    check_vec("rd_held",    sl_if.SDD_OUT, 8'h33);

    // Write plus clear: write wins and overrun is cleared
    write_cmd(8'h44);
    write_cmd(8'h66);
    check_vec("pre_wc_ovr", {7'h0, sl_if.CMD_OVR}, 8'h01);
    sl_if.M68K_DATA = 8'h55;
    pulse(S_SDW | S_CLR);
    check_vec("wc_sdd_out", sl_if.SDD_OUT, 8'h55);
    check_vec("wc_flags", {6'h0, sl_if.CMD_PENDING, sl_if.CMD_OVR}, 8'h02);
`else
    // FIFO: fill past capacity
    for (int i = 1; i <= 5; i++) begin
      write_cmd(8'(i));
    end
    check_vec("ff_ovr",     {7'h0, sl_if.CMD_OVR}, 8'h01);
    check_vec("ff_pending", {7'h0, sl_if.CMD_PENDING}, 8'h01);
    for (int i = 1; i <= 4; i++) begin
      check_vec($sformatf("ff_pop%0d", i), sl_if.SDD_OUT, 8'(i));
      pulse(S_Z80R);
    end
    check_vec("ff_empty", {7'h0, sl_if.CMD_PENDING}, 8'h00);
    check_vec("ff_held",  sl_if.SDD_OUT, 8'h04);

    // Push and pop on an empty FIFO
    sl_if.M68K_DATA = 8'h7E;
    pulse(S_SDW | S_Z80R);
    check_vec("ff_pass_out", sl_if.SDD_OUT, 8'h7E);
    check_vec("ff_pass_pending", {7'h0, sl_if.CMD_PENDING}, 8'h00);

    // Flush
    write_cmd(8'h21);
    pulse(S_CLR);
    check_vec("ff_flush_out", sl_if.SDD_OUT, 8'h00);
    check_vec("ff_flush_flags", {6'h0, sl_if.CMD_PENDING, sl_if.CMD_OVR}, 8'h00);
`endif

    // Reset mid-operation with nSDW falling on the reset edge and held low
    // through release
    write_cmd(8'h99);
    rst = 1'b1;
    sl_if.M68K_DATA = 8'hC3;
    sl_if.nSDW = 1'b0;
    tick();
    check_vec("mid_rst_out", sl_if.SDD_OUT, 8'h00);
    check_vec("mid_rst_flags", {5'h0, sl_if.CMD_PENDING, sl_if.CMD_OVR,
              sl_if.NMI_REQ}, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_vec($sformatf("held_nmi%0d", i), {7'h0, sl_if.NMI_REQ}, 8'h00);
    end
    check_vec("held_out",     sl_if.SDD_OUT, 8'h00);
    check_vec("held_pending", {7'h0, sl_if.CMD_PENDING}, 8'h00);
    strobe_off();

    // A fresh falling edge after release is accepted
    sl_if.M68K_DATA = 8'hE1;
    strobe_on(S_SDW);
    check_vec("post_nmi", {7'h0, sl_if.NMI_REQ}, 8'h01);
    check_vec("post_out", sl_if.SDD_OUT, 8'hE1);
    strobe_off();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
`default_nettype wire
